rf_write_arbiter: RTL and testbench

- Owns the single write port (we3/a3/wd3) of the 32x32 register file.
- After reset, optionally sequences a clear of x1..x31 to zero.
- Then shares the port between two writeback requesters: req0 (ALU/execute) and req1 (load/memory). It uses valid/ready handshakes and round-robin arbitration.
- Sits between the writeback stage and the register file; drives the register-file write inputs from registers.

---
 rtl/rv32_pkg.sv | 19 +
 rtl/rr_arb2.sv | 30 +++
 rtl/rf_write_arbiter.sv | 112 +++++++++++
 tb/tb_rf_write_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared register-file constants and types for the writeback path.
// Holds the write request record and the write-port owner's state encoding.
package rv32_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_req_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. When both requesters are asking, the one that
// was not served most recently wins; a lone requester always wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // 1 means requester 1 was served last, so requester 0 wins the next tie.
  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      grant[0] = req[0] & (~req[1] | last_grant);
      grant[1] = req[1] & (~req[0] | ~last_grant);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Owner of the register-file write port: clears x1..x31 after reset, then
// shares the port between the execute and load writeback requesters.
module rf_write_arbiter
  import rv32_pkg::*;
#(
  parameter int ADDR_W         = RF_ADDR_W,
  parameter int DATA_W         = RF_DATA_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              we3,
  output logic [ADDR_W-1:0] a3,
  output logic [DATA_W-1:0] wd3,
  output logic              init_done
);

  // Handshake: a write transfers in any cycle where valid and ready are both
  // high. Ready is combinational from both valids and the round-robin pointer,
  // so a requester must hold valid/addr/data until it sees ready; dropping
  // valid earlier simply withdraws the request.

  localparam logic [ADDR_W-1:0] FIRST_REG = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_REG  = '1;

  arb_state_t        state;
  arb_state_t        state_next;
  logic [ADDR_W-1:0] cnt;
  logic [1:0]        grant;
  logic              we3_next;
  logic [ADDR_W-1:0] a3_next;
  logic [DATA_W-1:0] wd3_next;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state == RUN),
    .req    ({req1_valid, req0_valid}),
    .grant  (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR_ON_RESET ? INIT : RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (state == INIT && cnt == LAST_REG) begin
      state_next = RUN;
    end
  end

  // Writes to x0 are consumed like any other but never raise the enable.
  always_comb begin
    we3_next = 1'b0;
    a3_next  = a3;
    wd3_next = wd3;
    case (state)
      INIT: begin
        we3_next = 1'b1;
        a3_next  = cnt;
        wd3_next = '0;
      end
      RUN: begin
        if (grant[0]) begin
          we3_next = |req0_addr;
          a3_next  = req0_addr;
          wd3_next = req0_data;
        end else if (grant[1]) begin
          we3_next = |req1_addr;
          a3_next  = req1_addr;
          wd3_next = req1_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3       <= 1'b0;
      a3        <= '0;
      wd3       <= '0;
      init_done <= 1'b0;
      cnt       <= FIRST_REG;
    end else begin
      we3       <= we3_next;
      a3        <= a3_next;
      wd3       <= wd3_next;
      init_done <= (state_next == RUN);
      if (state == INIT) begin
        cnt <= cnt + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus a randomized run checked
// against a round-robin reference model. dut_a clears on reset, dut_b does not.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n_a = 1'b0;
  logic        rst_n_b = 1'b0;
  logic        req0_valid = 1'b0;
  logic [4:0]  req0_addr = '0;
  logic [31:0] req0_data = '0;
  logic        req1_valid = 1'b0;
  logic [4:0]  req1_addr = '0;
  logic [31:0] req1_data = '0;

  logic        a_req0_ready, a_req1_ready, a_we3, a_init_done;
  logic [4:0]  a_a3;
  logic [31:0] a_wd3;
  logic        b_req0_ready, b_req1_ready, b_we3, b_init_done;
  logic [4:0]  b_a3;
  logic [31:0] b_wd3;

  int errors = 0;
  int checks = 0;

  // Reference model: who was served last, and the last address/data written.
  int          model_last;
  logic [4:0]  model_a3;
  logic [31:0] model_wd3;
  logic [37:0] exp_q[$];

  always #5 clk = ~clk;

  rf_write_arbiter #(.ADDR_W(5), .DATA_W(32), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n_a),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(a_req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(a_req1_ready),
    .we3(a_we3), .a3(a_a3), .wd3(a_wd3), .init_done(a_init_done)
  );

  rf_write_arbiter #(.ADDR_W(5), .DATA_W(32), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n_b),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(b_req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(b_req1_ready),
    .we3(b_we3), .a3(b_a3), .wd3(b_wd3), .init_done(b_init_done)
  );

  // Expected winner: -1 none, otherwise the requester index.
  function automatic int model_pick(input logic v0, input logic v1);
    if (v0 && v1) return (model_last == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Expected register-file port after the edge that follows a pick.
  function automatic logic [37:0] model_commit(input int pick, input logic [4:0] addr,
                                               input logic [31:0] data);
    logic we;
    we = 1'b0;
    if (pick >= 0) begin
      model_last = pick;
      model_a3   = addr;
      model_wd3  = data;
      we         = (addr != 5'd0);
    end
    return {we, model_a3, model_wd3};
  endfunction

  function automatic void model_after_clear();
    model_last = 1;
    model_a3   = 5'd31;
    model_wd3  = 32'd0;
  endfunction

  // Called just after reset release at a negedge; walks all 31 clear writes.
  task automatic run_clear(input string tag);
    for (int k = 1; k <= 31; k++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_addr  = 5'($urandom_range(0, 31));
      req1_addr  = 5'($urandom_range(0, 31));
      #1;
      checks++;
      if ({a_req0_ready, a_req1_ready} !== 2'b00) begin
        errors++;
        $display("FAIL %s_ready_in_init k=%0d: got %b expected 00", tag, k, {a_req0_ready, a_req1_ready});
      end
      @(negedge clk);
      checks++;
      if (a_we3 !== 1'b1 || a_a3 !== 5'(k) || a_wd3 !== 32'd0) begin
        errors++;
        $display("FAIL %s_clear_write k=%0d: got we=%b a3=%0d wd3=%h expected we=1 a3=%0d wd3=0",
                 tag, k, a_we3, a_a3, a_wd3, k);
      end
      if (k < 31) begin
        checks++;
        if (a_init_done !== 1'b0) begin
          errors++;
          $display("FAIL %s_init_done_early k=%0d: got %b expected 0", tag, k, a_init_done);
        end
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_we3 !== 1'b0 || a_init_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_after_clear: got we=%b init_done=%b expected we=0 init_done=1", tag, a_we3, a_init_done);
    end
    model_after_clear();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({a_we3, a_a3, a_wd3, a_init_done} !== 39'd0) begin
      errors++;
      $display("FAIL reset_a: got we=%b a3=%0d wd3=%h done=%b expected all 0", a_we3, a_a3, a_wd3, a_init_done);
    end
    checks++;
    if ({b_we3, b_a3, b_wd3, b_init_done} !== 39'd0) begin
      errors++;
      $display("FAIL reset_b: got we=%b a3=%0d wd3=%h done=%b expected all 0", b_we3, b_a3, b_wd3, b_init_done);
    end
  endtask

  task automatic test_clear();
    rst_n_a = 1'b1;
    run_clear("clear");
  endtask

  task automatic test_contention();
    int pick;
    int want [4] = '{0, 1, 0, 1};
    logic [37:0] exp;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11;
      req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h22;
      #1;
      pick = model_pick(1'b1, 1'b1);
      checks++;
      if (pick != want[i] || {a_req1_ready, a_req0_ready} !== (pick == 1 ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL contention_grant i=%0d: got r0=%b r1=%b expected grant %0d", i, a_req0_ready, a_req1_ready, want[i]);
      end
      exp_q.push_back(model_commit(pick, pick == 1 ? 5'd4 : 5'd3, pick == 1 ? 32'h22 : 32'h11));
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if ({a_we3, a_a3, a_wd3} !== exp) begin
        errors++;
        $display("FAIL contention_write i=%0d: got %h expected %h", i, {a_we3, a_a3, a_wd3}, exp);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    req1_valid = 1'b0;
    #1;
    checks++;
    if (a_req0_ready !== 1'b1 || a_req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: got r0=%b r1=%b expected r0=1 r1=0", a_req0_ready, a_req1_ready);
    end
    void'(model_commit(0, 5'd5, 32'hDEADBEEF));
    @(negedge clk);
    req0_valid = 1'b0;
    checks++;
    if (a_we3 !== 1'b1 || a_a3 !== 5'd5 || a_wd3 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_write: got we=%b a3=%0d wd3=%h expected we=1 a3=5 wd3=deadbeef", a_we3, a_a3, a_wd3);
    end
    @(negedge clk);
    checks++;
    if (a_we3 !== 1'b0 || a_a3 !== 5'd5 || a_wd3 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_idle: got we=%b a3=%0d wd3=%h expected we=0 a3=5 wd3=deadbeef", a_we3, a_a3, a_wd3);
    end
  endtask

  task automatic test_x0();
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFFFFFF;
    req0_valid = 1'b0;
    #1;
    checks++;
    if (a_req1_ready !== 1'b1 || a_req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL x0_ready: got r0=%b r1=%b expected r0=0 r1=1", a_req0_ready, a_req1_ready);
    end
    void'(model_commit(1, 5'd0, 32'hFFFFFFFF));
    @(negedge clk);
    checks++;
    if (a_we3 !== 1'b0 || a_a3 !== 5'd0 || a_wd3 !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL x0_write: got we=%b a3=%0d wd3=%h expected we=0 a3=0 wd3=ffffffff", a_we3, a_a3, a_wd3);
    end
    // Pointer moved to requester 1, so requester 0 takes the next tie.
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h22;
    #1;
    checks++;
    if (a_req0_ready !== 1'b1 || a_req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL x0_pointer: got r0=%b r1=%b expected r0=1 r1=0", a_req0_ready, a_req1_ready);
    end
    void'(model_commit(0, 5'd3, 32'h11));
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_random();
    logic        v [2] = '{1'b0, 1'b0};
    logic [4:0]  ad [2];
    logic [31:0] dt [2];
    logic [37:0] exp;
    int pick;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!v[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            v[i]  = 1'b1;
            ad[i] = 5'($urandom_range(0, 31));
            dt[i] = $urandom;
          end
        end else if ($urandom_range(0, 9) == 0) begin
          v[i] = 1'b0;
        end
      end
      req0_valid = v[0]; req0_addr = ad[0]; req0_data = dt[0];
      req1_valid = v[1]; req1_addr = ad[1]; req1_data = dt[1];
      #1;
      pick = model_pick(v[0], v[1]);
      checks++;
      if (a_req0_ready !== (pick == 0) || a_req1_ready !== (pick == 1)) begin
        errors++;
        $display("FAIL random_grant c=%0d: got r0=%b r1=%b expected pick %0d", c, a_req0_ready, a_req1_ready, pick);
      end
      exp_q.push_back(model_commit(pick, pick >= 0 ? ad[pick] : 5'd0, pick >= 0 ? dt[pick] : 32'd0));
      if (pick >= 0) v[pick] = 1'b0;
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if ({a_we3, a_a3, a_wd3} !== exp) begin
        errors++;
        $display("FAIL random_write c=%0d: got %h expected %h", c, {a_we3, a_a3, a_wd3}, exp);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_init();
    bit found = 0;
    rst_n_a = 1'b0;
    @(negedge clk);
    rst_n_a = 1'b1;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (a_we3 === 1'b1 && a_a3 === 5'd10) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_init_reach: got no a3=10 within 40 cycles expected a3=10");
    end
    rst_n_a = 1'b0;
    #1;
    checks++;
    if ({a_we3, a_a3, a_wd3, a_init_done} !== 39'd0) begin
      errors++;
      $display("FAIL mid_init_async: got we=%b a3=%0d wd3=%h done=%b expected all 0", a_we3, a_a3, a_wd3, a_init_done);
    end
    @(negedge clk);
    rst_n_a = 1'b1;
    run_clear("restart");
  endtask

  task automatic test_no_clear();
    logic [31:0] d;
    d = $urandom;
    rst_n_a = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = d;
    req1_valid = 1'b0;
    rst_n_b = 1'b1;
    #1;
    checks++;
    if (b_req0_ready !== 1'b1 || b_req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL noclear_ready: got r0=%b r1=%b expected r0=1 r1=0", b_req0_ready, b_req1_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    checks++;
    if (b_we3 !== 1'b1 || b_a3 !== 5'd7 || b_wd3 !== d || b_init_done !== 1'b1) begin
      errors++;
      $display("FAIL noclear_write: got we=%b a3=%0d wd3=%h done=%b expected we=1 a3=7 wd3=%h done=1",
               b_we3, b_a3, b_wd3, b_init_done, d);
    end
    @(negedge clk);
    checks++;
    if (b_we3 !== 1'b0 || b_init_done !== 1'b1) begin
      errors++;
      $display("FAIL noclear_idle: got we=%b done=%b expected we=0 done=1", b_we3, b_init_done);
    end
  endtask

  initial begin
    model_after_clear();
    test_reset();
    test_clear();
    test_contention();
    test_single();
    test_x0();
    test_random();
    test_reset_mid_init();
    test_no_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
